// File: rtl/uart_to_axis_m.sv
// Polls a UART RX port (status then data) and forwards each byte as one AXI-Stream beat; byte appears on tvalid 5 edges after a poll starts.
// A stalled tready holds tdata/tvalid and suspends all polling, so no byte is dropped; receive errors accumulate in sticky rx_err.
module uart_to_axis_m #(
    parameter logic [1:0]  STAT_ADDR = 2'd1,
    parameter logic [1:0]  DATA_ADDR = 2'd0,
    parameter int unsigned POLL_GAP  = 16
) (
    input  logic       clk,
    input  logic       rst,
    output logic       rd,
    output logic [1:0] raddr,
    input  logic [7:0] rdata,
    output logic [7:0] term_out_tdata,
    output logic       term_out_tvalid,
    input  logic       term_out_tready,
    output logic       rx_err
);

    localparam int GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(POLL_GAP);

    typedef enum logic [2:0] {
        IDLE,
        S_REQ,
        S_CHK,
        D_REQ,
        D_CAP,
        OUT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [GW-1:0] gap;
    logic [GW-1:0] gap_nxt;
    logic          rd_nxt;
    logic [1:0]    raddr_nxt;
    logic [7:0]    tdata_nxt;
    logic          tvalid_nxt;
    logic          rx_err_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            gap             <= '0;
            rd              <= 1'b0;
            raddr           <= 2'd0;
            term_out_tdata  <= 8'h00;
            term_out_tvalid <= 1'b0;
            rx_err          <= 1'b0;
        end else begin
            state           <= state_nxt;
            gap             <= gap_nxt;
            rd              <= rd_nxt;
            raddr           <= raddr_nxt;
            term_out_tdata  <= tdata_nxt;
            term_out_tvalid <= tvalid_nxt;
            rx_err          <= rx_err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gap == '0) state_nxt = S_REQ;
            S_REQ:   state_nxt = S_CHK;
            S_CHK:   state_nxt = rdata[0] ? IDLE : D_REQ;
            D_REQ:   state_nxt = D_CAP;
            D_CAP:   state_nxt = OUT;
            OUT:     if (term_out_tvalid && term_out_tready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rd defaults low so every read strobe lasts exactly one cycle.
    always_comb begin
        gap_nxt    = gap;
        rd_nxt     = 1'b0;
        raddr_nxt  = raddr;
        tdata_nxt  = term_out_tdata;
        tvalid_nxt = term_out_tvalid;
        rx_err_nxt = rx_err;
        case (state)
            IDLE: begin
                if (gap == '0) begin
                    rd_nxt    = 1'b1;
                    raddr_nxt = STAT_ADDR;
                end else begin
                    gap_nxt = gap - GW'(1);
                end
            end
            S_CHK: begin
                rx_err_nxt = rx_err | rdata[1] | rdata[2];
                if (rdata[0]) begin
                    gap_nxt = GAP_LOAD;
                end else begin
                    rd_nxt    = 1'b1;
                    raddr_nxt = DATA_ADDR;
                end
            end
            D_CAP: begin
                tdata_nxt  = rdata;
                tvalid_nxt = 1'b1;
            end
            OUT: begin
                if (term_out_tvalid && term_out_tready) begin
                    tvalid_nxt = 1'b0;
                    gap_nxt    = GAP_LOAD;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_to_axis_m.sv
// Bench for uart_to_axis_m: behavioural UART read port plus an AXI-Stream scoreboard.
module tb_uart_to_axis_m;

    localparam int G = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rd;
    logic [1:0] raddr;
    logic [7:0] rdata = 8'h00;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready = 1'b0;
    logic       rx_err;

    always #5 clk = ~clk;

    uart_to_axis_m #(
        .STAT_ADDR(2'd1),
        .DATA_ADDR(2'd0),
        .POLL_GAP (G)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rd             (rd),
        .raddr          (raddr),
        .rdata          (rdata),
        .term_out_tdata (tdata),
        .term_out_tvalid(tvalid),
        .term_out_tready(tready),
        .rx_err         (rx_err)
    );

    int n_tests = 0;
    int n_fail = 0;
    int data_rd_cnt = 0;
    int hs_cnt = 0;
    int cyc = 0;
    logic [7:0] stat_q[$];
    logic [7:0] data_q[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // UART model: answers a read one cycle after the strobe; empty status once the queue drains.
    always @(posedge clk) begin
        if (rd === 1'b1) begin
            if (raddr == 2'd1) begin
                #1 rdata = (stat_q.size() > 0) ? stat_q.pop_front() : 8'h01;
            end else begin
                data_rd_cnt++;
                #1 rdata = (data_q.size() > 0) ? data_q.pop_front() : 8'hEE;
            end
        end
    end

    logic       p_vld = 1'b0;
    logic       p_hs = 1'b0;
    logic       p_rd = 1'b0;
    logic [7:0] p_dat = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            p_vld = 1'b0;
            p_hs  = 1'b0;
            p_rd  = 1'b0;
        end else begin
            if (p_vld && !p_hs) begin
                chk("tvalid_hold", tvalid, 1);
                chk("tdata_hold", tdata, p_dat);
            end
            if (p_rd) chk("rd_one_cycle", rd, 0);
            if (tvalid) chk("no_rd_while_tvalid", rd, 0);
            if (tvalid && tready) begin
                hs_cnt++;
                if (exp_q.size() == 0) chk("sb_unexpected_beat", exp_q.size(), 1);
                else chk("sb_tdata", tdata, exp_q.pop_front());
            end
            p_vld = tvalid;
            p_hs  = tvalid && tready;
            p_rd  = rd;
            p_dat = tdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd(output int c);
        c = -1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rd) begin
                c = cyc;
                break;
            end
        end
        chk("rd_seen", (c >= 0), 1);
    endtask

    task automatic wait_vld();
        for (int i = 0; i < 100 && !tvalid; i++) tick();
        chk("tvalid_seen", tvalid, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, dr;

        // Reset values, then byte 8'h00 with tready high from the start.
        tready = 1'b1;
        stat_q.push_back(8'h00);
        data_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_rd", rd, 0);
        chk("rst_raddr", raddr, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_rx_err", rx_err, 0);
        rst = 1'b0;
        tick(); chk("e1_rd", rd, 1); chk("e1_raddr", raddr, 1);
        tick(); chk("e2_rd", rd, 0);
        tick(); chk("e3_rd", rd, 1); chk("e3_raddr", raddr, 0);
        tick(); chk("e4_rd", rd, 0); chk("e4_tvalid", tvalid, 0);
        tick(); chk("e5_tvalid", tvalid, 1); chk("e5_tdata", tdata, 8'h00);
        tick(); chk("e6_tvalid", tvalid, 0);
        chk("hs_after_first", hs_cnt, 1);

        // Empty status: status-only polls spaced G+3 apart.
        dr = data_rd_cnt;
        wait_rd(t0); chk("poll0_raddr", raddr, 1);
        wait_rd(t1); chk("poll1_raddr", raddr, 1);
        wait_rd(t2); chk("poll2_raddr", raddr, 1);
        chk("poll_gap_a", t1 - t0, G + 3);
        chk("poll_gap_b", t2 - t1, G + 3);
        chk("no_data_reads", data_rd_cnt, dr);
        chk("empty_tvalid", tvalid, 0);

        // Backpressure: 8'h41 held for 10 cycles with polling stalled.
        tready = 1'b0;
        stat_q.push_back(8'h00);
        data_q.push_back(8'h41);
        exp_q.push_back(8'h41);
        wait_vld();
        dr = data_rd_cnt;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_tvalid", tvalid, 1);
            chk("bp_tdata", tdata, 8'h41);
            chk("bp_rd", rd, 0);
        end
        tready = 1'b1;
        tick();
        chk("bp_released", tvalid, 0);
        chk("hs_after_bp", hs_cnt, 2);
        chk("bp_no_extra_reads", data_rd_cnt, dr);

        // Error status 8'h06: byte still forwarded, rx_err sticky across clean polls.
        stat_q.push_back(8'h06);
        data_q.push_back(8'h5A);
        exp_q.push_back(8'h5A);
        for (int i = 0; i < 100 && !rx_err; i++) tick();
        chk("rx_err_set", rx_err, 1);
        wait_rd(t0);
        wait_rd(t1);
        wait_rd(t2);
        tick();
        chk("rx_err_sticky", rx_err, 1);
        chk("hs_after_err", hs_cnt, 3);
        chk("sb_drained", exp_q.size(), 0);

        // Reset while a beat is pending in OUT.
        tready = 1'b0;
        stat_q.push_back(8'h00);
        data_q.push_back(8'h33);
        exp_q.push_back(8'h33);
        wait_vld();
        chk("out_tdata", tdata, 8'h33);
        rst = 1'b1;
        tick();
        chk("midrst_tvalid", tvalid, 0);
        chk("midrst_rd", rd, 0);
        chk("midrst_rx_err", rx_err, 0);
        void'(exp_q.pop_front());
        tick();
        rst = 1'b0;
        tready = 1'b1;
        tick(); chk("re_e1_rd", rd, 1); chk("re_e1_raddr", raddr, 1);
        tick(); chk("re_e2_rd", rd, 0);

        repeat (20) tick();
        chk("final_sb_empty", exp_q.size(), 0);
        chk("final_hs", hs_cnt, 3);
        chk("final_rx_err", rx_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
